// File: rtl/aq_axi_sdma64_sfifo.sv
// Single-clock synchronous FIFO for SDMA64 buffering: selectable FWFT or registered read,
// runtime almost-full/almost-empty thresholds, synchronous flush and over/underflow pulses.
module aq_axi_sdma64_sfifo #(
   parameter int DATA_WIDTH = 65,
   parameter int ADDR_WIDTH = 9,
   parameter int FWFT       = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FLUSH,
   input  logic                  WREN,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic                  FULL,
   output logic                  AFULL,
   input  logic [ADDR_WIDTH:0]   AFULL_THRESH,
   output logic                  WRERR,
   input  logic                  RDEN,
   output logic [DATA_WIDTH-1:0] DO,
   output logic                  EMPTY,
   output logic                  AEMPTY,
   input  logic [ADDR_WIDTH:0]   AEMPTY_THRESH,
   output logic                  RDERR,
   output logic [ADDR_WIDTH:0]   COUNT
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  wrerr_q, wrerr_d;
   logic                  rderr_q, rderr_d;
   logic                  full, empty, wr_acc, rd_acc;

   // Acceptance is decided purely on the registered count, so no write-through-full.
   always_comb begin
      full   = (count_q == CNT_FULL);
      empty  = (count_q == '0);
      wr_acc = WREN & ~full & ~FLUSH;
      rd_acc = RDEN & ~empty & ~FLUSH;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      wrerr_d = WREN & full & ~FLUSH;
      rderr_d = RDEN & empty & ~FLUSH;
      if (FLUSH) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PTR_ONE;
         if (rd_acc) rptr_d = rptr_q + PTR_ONE;
         if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
         else if (!wr_acc && rd_acc) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         wrerr_q <= 1'b0;
         rderr_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         wrerr_q <= wrerr_d;
         rderr_q <= rderr_d;
      end
   end

   // Storage has no reset so it can map onto RAM resources.
   always_ff @(posedge CLK) begin
      if (wr_acc) mem[wptr_q] <= DI;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign DO = mem[rptr_q];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] do_q, do_d;

         always_comb begin
            do_d = do_q;
            if (rd_acc) do_d = mem[rptr_q];
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) do_q <= '0;
            else     do_q <= do_d;
         end

         assign DO = do_q;
      end
   endgenerate

   assign FULL   = full;
   assign EMPTY  = empty;
   assign AFULL  = (count_q >= AFULL_THRESH);
   assign AEMPTY = (count_q <= AEMPTY_THRESH);
   assign WRERR  = wrerr_q;
   assign RDERR  = rderr_q;
   assign COUNT  = count_q;

endmodule

// File: tb/tb_aq_axi_sdma64_sfifo.sv
// Scoreboard bench for aq_axi_sdma64_sfifo: an FWFT and a standard-read instance share one
// stimulus stream; a queue-based reference model predicts count, flags, errors and read data.
module tb_aq_axi_sdma64_sfifo;

   localparam int DW    = 65;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          FLUSH = 1'b0;
   logic          WREN = 1'b0;
   logic          RDEN = 1'b0;
   logic [DW-1:0] DI = '0;
   logic [AW:0]   AFULL_THRESH = 5'd12;
   logic [AW:0]   AEMPTY_THRESH = 5'd3;

   logic          fullF, afullF, wrerrF, emptyF, aemptyF, rderrF;
   logic [DW-1:0] doF;
   logic [AW:0]   countF;
   logic          fullS, afullS, wrerrS, emptyS, aemptyS, rderrS;
   logic [DW-1:0] doS;
   logic [AW:0]   countS;

   // Reference model: the FIFO contents as a plain queue plus expected registered outputs.
   logic [DW-1:0] modelQ[$];
   logic [DW-1:0] expQF[$];
   logic [DW-1:0] expQS[$];
   logic [DW-1:0] expDoS = '0;
   logic          expWrerr = 1'b0;
   logic          expRderr = 1'b0;

   int checkCount = 0;
   int passCount  = 0;

   aq_axi_sdma64_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dutF (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WREN(WREN), .DI(DI),
      .FULL(fullF), .AFULL(afullF), .AFULL_THRESH(AFULL_THRESH), .WRERR(wrerrF),
      .RDEN(RDEN), .DO(doF), .EMPTY(emptyF), .AEMPTY(aemptyF),
      .AEMPTY_THRESH(AEMPTY_THRESH), .RDERR(rderrF), .COUNT(countF)
   );

   aq_axi_sdma64_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dutS (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WREN(WREN), .DI(DI),
      .FULL(fullS), .AFULL(afullS), .AFULL_THRESH(AFULL_THRESH), .WRERR(wrerrS),
      .RDEN(RDEN), .DO(doS), .EMPTY(emptyS), .AEMPTY(aemptyS),
      .AEMPTY_THRESH(AEMPTY_THRESH), .RDERR(rderrS), .COUNT(countS)
   );

   always #5 CLK = ~CLK;

   // Hard time limit so a stuck run still terminates with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
   endtask

   // Compares every count/flag/error output of both instances against the model.
   task automatic checkOutput();
      int c;
      c = modelQ.size();
      checkVal("countF", DW'(countF), DW'(c));
      checkVal("countS", DW'(countS), DW'(c));
      checkVal("fullF", DW'(fullF), DW'(c == DEPTH));
      checkVal("fullS", DW'(fullS), DW'(c == DEPTH));
      checkVal("emptyF", DW'(emptyF), DW'(c == 0));
      checkVal("emptyS", DW'(emptyS), DW'(c == 0));
      checkVal("afullF", DW'(afullF), DW'(c >= int'(AFULL_THRESH)));
      checkVal("afullS", DW'(afullS), DW'(c >= int'(AFULL_THRESH)));
      checkVal("aemptyF", DW'(aemptyF), DW'(c <= int'(AEMPTY_THRESH)));
      checkVal("aemptyS", DW'(aemptyS), DW'(c <= int'(AEMPTY_THRESH)));
      checkVal("wrerrF", DW'(wrerrF), DW'(expWrerr));
      checkVal("wrerrS", DW'(wrerrS), DW'(expWrerr));
      checkVal("rderrF", DW'(rderrF), DW'(expRderr));
      checkVal("rderrS", DW'(rderrS), DW'(expRderr));
      checkVal("doS", doS, expDoS);
      if (c > 0) checkVal("doF_head", doF, modelQ[0]);
   endtask

   // Drives one cycle at the falling edge, advances the model after the rising edge, checks.
   task automatic applyStimulus(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] data);
      int  c;
      bit  wacc, racc;
      WREN  = wr;
      RDEN  = rd;
      FLUSH = fl;
      DI    = data;
      c     = modelQ.size();
      wacc  = wr && !fl && (c < DEPTH);
      racc  = rd && !fl && (c > 0);
      @(posedge CLK);
      #2;
      expWrerr = wr && !fl && (c == DEPTH);
      expRderr = rd && !fl && (c == 0);
      if (fl) begin
         modelQ.delete();
         expQF.delete();
         expQS.delete();
      end else begin
         if (racc) expDoS = modelQ.pop_front();
         if (wacc) begin
            modelQ.push_back(data);
            expQF.push_back(data);
            expQS.push_back(data);
         end
      end
      checkOutput();
      @(negedge CLK);
   endtask

   // Asserts reset between edges; outputs must reach reset values without waiting for a clock.
   task automatic doReset();
      RST = 1'b1;
      #1;
      modelQ.delete();
      expQF.delete();
      expQS.delete();
      expDoS   = '0;
      expWrerr = 1'b0;
      expRderr = 1'b0;
      checkOutput();
      WREN  = 1'b0;
      RDEN  = 1'b0;
      FLUSH = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   function automatic logic [DW-1:0] randWord();
      return {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
   endfunction

   // Monitor: pops the scoreboard whenever a DUT presents a word that the consumer takes.
   initial begin
      logic          capRd, capFl, capRst, capEmptyF, capEmptyS;
      logic [DW-1:0] capDoF, expWord;
      forever begin
         @(negedge CLK);
         #4;
         capRd     = RDEN;
         capFl     = FLUSH;
         capRst    = RST;
         capEmptyF = emptyF;
         capEmptyS = emptyS;
         capDoF    = doF;
         @(posedge CLK);
         #1;
         if (capRd && !capFl && !capRst && !RST) begin
            if (!capEmptyF) begin
               if (expQF.size() == 0) begin
                  checkCount++;
                  $display("[TB] FAIL scoreboardF actual=pop expected=no_data at %0t", $time);
               end else begin
                  expWord = expQF.pop_front();
                  checkVal("readF", capDoF, expWord);
               end
            end
            if (!capEmptyS) begin
               if (expQS.size() == 0) begin
                  checkCount++;
                  $display("[TB] FAIL scoreboardS actual=pop expected=no_data at %0t", $time);
               end else begin
                  expWord = expQS.pop_front();
                  checkVal("readS", doS, expWord);
               end
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] w;
      repeat (2) @(negedge CLK);
      checkOutput();
      RST = 1'b0;
      @(negedge CLK);

      $display("[TB] fill to full, then overflow");
      for (int i = 1; i <= DEPTH; i++) begin
         w = {1'b1, 64'(i)};
         applyStimulus(1'b1, 1'b0, 1'b0, w);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, randWord());
      applyStimulus(1'b0, 1'b0, 1'b0, '0);

      $display("[TB] simultaneous read/write at full, then steady state across wrap");
      applyStimulus(1'b1, 1'b1, 1'b0, randWord());
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 1'b0, randWord());

      $display("[TB] flush with write pending");
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, randWord());
      applyStimulus(1'b1, 1'b0, 1'b1, randWord());
      applyStimulus(1'b0, 1'b0, 1'b0, '0);

      $display("[TB] single word latency and underflow");
      applyStimulus(1'b1, 1'b0, 1'b0, 65'hA5);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, 65'h11);
      applyStimulus(1'b1, 1'b0, 1'b0, 65'h22);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);

      $display("[TB] threshold sweep fill and drain");
      AFULL_THRESH  = 5'd12;
      AEMPTY_THRESH = 5'd3;
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, randWord());
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, randWord());
      applyStimulus(1'b1, 1'b1, 1'b0, randWord());
      applyStimulus(1'b0, 1'b1, 1'b0, '0);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            AFULL_THRESH  = 5'($urandom_range(1, DEPTH));
            AEMPTY_THRESH = 5'($urandom_range(0, DEPTH - 1));
         end
         applyStimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                       1'($urandom_range(0, 59) == 0), randWord());
      end

      $display("[TB] reset mid-burst");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, randWord());
      applyStimulus(1'b1, 1'b1, 1'b0, randWord());
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, randWord());
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

      repeat (2) @(negedge CLK);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
